// File: rtl/operand_combiner.sv
// Two operand FIFOs feed a one-result-per-cycle combine stage (XOR/AND/OR/ADD) into a result FIFO,
// all reached through a small register-mapped write port and a registered read port.
module operand_combiner #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              write_en,
    input  logic [2:0]        write_address,
    input  logic [DATA_W-1:0] write_data,
    output logic              write_rdy,
    input  logic              read_en,
    input  logic [2:0]        read_address,
    output logic [DATA_W-1:0] read_data,
    output logic              read_rdy
);

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];
    logic [DATA_W-1:0] y_mem [DEPTH];

    logic [PTR_W-1:0]  a_wr, a_rd, b_wr, b_rd, y_wr, y_rd;
    logic [CNT_W-1:0]  a_lvl, b_lvl, y_lvl;
    logic [1:0]        mode;
    logic              a_ovf, b_ovf, y_unf;

    logic              wr_ok, rd_ok, fire, y_full;
    logic              a_push_req, b_push_req, a_push, b_push;
    logic              y_pop_req, y_pop, mode_wr, clr;
    logic [DATA_W-1:0] rd_value;

    function automatic logic [DATA_W-1:0] combine_op(input logic [1:0] op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        case (op)
            2'd0:    return a ^ b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a + b;
        endcase
    endfunction

    // Combine looks only at pre-edge levels, so a same-cycle Y read never frees space for it.
    always_comb begin
        wr_ok      = write_en && !RST;
        rd_ok      = read_en && !RST;
        y_full     = (y_lvl == FULL_LVL);
        fire       = (a_lvl != '0) && (b_lvl != '0) && !y_full;
        a_push_req = wr_ok && (write_address == 3'd4);
        b_push_req = wr_ok && (write_address == 3'd5);
        mode_wr    = wr_ok && (write_address == 3'd6);
        clr        = wr_ok && (write_address == 3'd7);
        a_push     = a_push_req && ((a_lvl != FULL_LVL) || fire);
        b_push     = b_push_req && ((b_lvl != FULL_LVL) || fire);
        y_pop_req  = rd_ok && (read_address == 3'd3);
        y_pop      = y_pop_req && (y_lvl != '0);
    end

    always_comb begin
        rd_value = '0;
        case (read_address)
            3'd0:    rd_value = DATA_W'(a_lvl);
            3'd1:    rd_value = DATA_W'(b_lvl);
            3'd2:    rd_value = DATA_W'(y_lvl);
            3'd3:    rd_value = (y_lvl != '0) ? y_mem[y_rd] : '0;
            3'd4:    rd_value = DATA_W'({y_full, y_unf, b_ovf, a_ovf});
            3'd5:    rd_value = DATA_W'(mode);
            default: rd_value = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (a_push) a_mem[a_wr] <= write_data;
        if (b_push) b_mem[b_wr] <= write_data;
        if (fire)   y_mem[y_wr] <= combine_op(mode, a_mem[a_rd], b_mem[b_rd]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_wr      <= '0;
            a_rd      <= '0;
            b_wr      <= '0;
            b_rd      <= '0;
            y_wr      <= '0;
            y_rd      <= '0;
            a_lvl     <= '0;
            b_lvl     <= '0;
            y_lvl     <= '0;
            mode      <= 2'd0;
            a_ovf     <= 1'b0;
            b_ovf     <= 1'b0;
            y_unf     <= 1'b0;
            write_rdy <= 1'b0;
            read_rdy  <= 1'b0;
            read_data <= '0;
        end else begin
            write_rdy <= 1'b1;
            read_rdy  <= read_en;
            if (read_en) read_data <= rd_value;

            if (a_push) a_wr <= a_wr + PTR_W'(1);
            if (b_push) b_wr <= b_wr + PTR_W'(1);
            if (fire) begin
                a_rd <= a_rd + PTR_W'(1);
                b_rd <= b_rd + PTR_W'(1);
                y_wr <= y_wr + PTR_W'(1);
            end
            if (y_pop) y_rd <= y_rd + PTR_W'(1);

            a_lvl <= a_lvl + CNT_W'(a_push) - CNT_W'(fire);
            b_lvl <= b_lvl + CNT_W'(b_push) - CNT_W'(fire);
            y_lvl <= y_lvl + CNT_W'(fire) - CNT_W'(y_pop);

            if (mode_wr) mode <= write_data[1:0];

            // A new error in the same cycle as a clear keeps its flag set.
            a_ovf <= (a_ovf && !clr) || (a_push_req && !a_push);
            b_ovf <= (b_ovf && !clr) || (b_push_req && !b_push);
            y_unf <= (y_unf && !clr) || (y_pop_req && !y_pop);
        end
    end

endmodule

// File: tb/tb_operand_combiner.sv
// Directed bench for operand_combiner (DATA_W=8, DEPTH=4): a vector table for the single-cycle
// register behaviour plus hand sequences for reset, Y backpressure/wrap and mid-run reset.
module tb_operand_combiner;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              write_en;
    logic [2:0]        write_address;
    logic [DATA_W-1:0] write_data;
    logic              write_rdy;
    logic              read_en;
    logic [2:0]        read_address;
    logic [DATA_W-1:0] read_data;
    logic              read_rdy;

    always #5 clk = ~clk;

    operand_combiner #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(clk),
        .RST(rst),
        .write_en(write_en),
        .write_address(write_address),
        .write_data(write_data),
        .write_rdy(write_rdy),
        .read_en(read_en),
        .read_address(read_address),
        .read_data(read_data),
        .read_rdy(read_rdy)
    );

    typedef struct packed {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [2:0] ra;
        logic       chk;
        logic [7:0] expd;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expd);
        applied++;
        if (act !== expd) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, expd);
        end
    endtask

    // One clock cycle with the given port values; returns 1 time unit after the edge.
    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] ra);
        write_en      = we;
        write_address = wa;
        write_data    = wd;
        read_en       = re;
        read_address  = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic add_wr(input logic [2:0] wa, input logic [7:0] wd);
        vecs.push_back('{we: 1'b1, wa: wa, wd: wd, re: 1'b0, ra: 3'd0, chk: 1'b0, expd: 8'h00});
    endtask

    task automatic add_rd(input logic [2:0] ra, input logic [7:0] expd);
        vecs.push_back('{we: 1'b0, wa: 3'd0, wd: 8'h00, re: 1'b1, ra: ra, chk: 1'b1, expd: expd});
    endtask

    task automatic add_idle();
        vecs.push_back('{we: 1'b0, wa: 3'd0, wd: 8'h00, re: 1'b0, ra: 3'd0, chk: 1'b0, expd: 8'h00});
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] a_val, b_val;

    initial begin
        // Reset with a write and a read requested: both must be ignored.
        rst = 1'b1;
        write_en = 1'b1; write_address = 3'd4; write_data = 8'h55;
        read_en = 1'b1;  read_address = 3'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset%0d write_rdy", i), write_rdy, 1'b0);
            check($sformatf("reset%0d read_rdy", i), read_rdy, 1'b0);
            check($sformatf("reset%0d read_data", i), read_data, 8'h00);
        end
        rst = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        check("write_rdy after reset", write_rdy, 1'b1);

        // Post-reset state
        add_rd(3'd0, 8'h00); add_rd(3'd1, 8'h00); add_rd(3'd2, 8'h00);
        add_rd(3'd4, 8'h00); add_rd(3'd5, 8'h00);
        // XOR default: 0xA5 ^ 0x3C
        add_wr(3'd4, 8'hA5); add_wr(3'd5, 8'h3C);
        add_rd(3'd2, 8'h00);                       // combine fires on this edge
        add_rd(3'd2, 8'h01);
        add_rd(3'd3, 8'h99);
        add_rd(3'd2, 8'h00);
        // ADD (carry dropped), AND, OR
        add_wr(3'd6, 8'h03); add_wr(3'd4, 8'hF0); add_wr(3'd5, 8'h20); add_idle(); add_rd(3'd3, 8'h10);
        add_wr(3'd6, 8'h01); add_wr(3'd4, 8'hF0); add_wr(3'd5, 8'h20); add_idle(); add_rd(3'd3, 8'h20);
        add_wr(3'd6, 8'h02); add_wr(3'd4, 8'hF0); add_wr(3'd5, 8'h20); add_idle(); add_rd(3'd3, 8'hF0);
        add_rd(3'd5, 8'h02);
        // A overflow with B empty, then clear
        for (int i = 1; i <= DEPTH + 1; i++) add_wr(3'd4, 8'(i));
        add_rd(3'd0, 8'h04);
        add_rd(3'd4, 8'h01);
        add_wr(3'd7, 8'hFF);
        add_rd(3'd4, 8'h00);
        // Push into full A on the same edge as a combine pop: accepted, level stays DEPTH
        add_wr(3'd5, 8'h00);
        add_wr(3'd4, 8'h09);
        add_rd(3'd0, 8'h04);
        add_rd(3'd4, 8'h00);
        // Fill Y from A = {2,3,4,9} (mode OR with zeros), check y_full, drain
        add_wr(3'd5, 8'h00); add_wr(3'd5, 8'h00); add_wr(3'd5, 8'h00); add_idle();
        add_rd(3'd2, 8'h04);
        add_rd(3'd4, 8'h08);
        add_rd(3'd3, 8'h01); add_rd(3'd3, 8'h02); add_rd(3'd3, 8'h03); add_rd(3'd3, 8'h04);
        add_wr(3'd5, 8'h00); add_idle(); add_rd(3'd3, 8'h09);
        // Underflow; clear coinciding with a new underflow keeps the flag
        add_rd(3'd3, 8'h00);
        add_rd(3'd4, 8'h04);
        vecs.push_back('{we: 1'b1, wa: 3'd7, wd: 8'h00, re: 1'b1, ra: 3'd3, chk: 1'b1, expd: 8'h00});
        add_rd(3'd4, 8'h04);
        add_wr(3'd7, 8'h00);
        add_rd(3'd4, 8'h00);
        // Writes to addresses 0-3 have no effect
        add_wr(3'd2, 8'hFF); add_wr(3'd0, 8'h03);
        add_rd(3'd5, 8'h02);
        add_rd(3'd0, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
            check($sformatf("vec%0d read_rdy", i), read_rdy, vecs[i].re);
            if (vecs[i].chk) check($sformatf("vec%0d read_data", i), read_data, vecs[i].expd);
        end

        // Backpressure and pointer wrap: 2*DEPTH XOR pairs, no reads
        drive(1'b1, 3'd6, 8'h00, 1'b0, 3'd0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            a_val = 8'h10 + 8'(i * 19);
            b_val = 8'hC3 + 8'(i * 7);
            exp_q.push_back(a_val ^ b_val);
            drive(1'b1, 3'd4, a_val, 1'b0, 3'd0);
            drive(1'b1, 3'd5, b_val, 1'b0, 3'd0);
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
        check("bp A level", read_data, 8'h04);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
        check("bp B level", read_data, 8'h04);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
        check("bp Y level", read_data, 8'h04);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4);
        check("bp status y_full", read_data, 8'h08);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
            check($sformatf("drain%0d", i), read_data, exp_q[i]);
        end
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
        check("drained Y level", read_data, 8'h00);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4);
        check("drained status", read_data, 8'h00);

        // Reset mid-operation discards FIFO contents and mode
        drive(1'b1, 3'd6, 8'h01, 1'b0, 3'd0);
        drive(1'b1, 3'd4, 8'h77, 1'b0, 3'd0);
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        rst = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
        check("mid-reset A level", read_data, 8'h00);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5);
        check("mid-reset mode", read_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
